// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = a - b with borrow out B, one bit per clock, LSB first.
// Each bit is a full subtractor formed from two chained half-subtractor cells.

module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic b
);

  assign d = x ^ y;
  assign b = ~x & y;

endmodule

module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             B
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sr, a_sr_n;
  logic [WIDTH-1:0] b_sr, b_sr_n;
  logic [WIDTH-1:0] res, res_n;
  logic [WIDTH-1:0] d_q, d_n;
  logic             b_q, b_n;
  logic             br, br_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             busy_n, done_n;

  // Per-bit full subtractor: a0 - b0 - br
  logic hs0_d, hs0_b, d_bit, hs1_b, br_next;

  half_subtractor u_hs0 (
    .x (a_sr[0]),
    .y (b_sr[0]),
    .d (hs0_d),
    .b (hs0_b)
  );

  half_subtractor u_hs1 (
    .x (hs0_d),
    .y (br),
    .d (d_bit),
    .b (hs1_b)
  );

  assign br_next = hs0_b | hs1_b;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      d_q   <= '0;
      b_q   <= 1'b0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      a_sr  <= a_sr_n;
      b_sr  <= b_sr_n;
      res   <= res_n;
      d_q   <= d_n;
      b_q   <= b_n;
      br    <= br_n;
      cnt   <= cnt_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_n = state;
    a_sr_n  = a_sr;
    b_sr_n  = b_sr;
    res_n   = res;
    d_n     = d_q;
    b_n     = b_q;
    br_n    = br;
    cnt_n   = cnt;

    case (state)
      S_IDLE, S_DONE: begin
        if (state == S_DONE) begin
          state_n = S_IDLE;
        end
        if (start) begin
          state_n = S_RUN;
          a_sr_n  = a;
          b_sr_n  = b;
          res_n   = '0;
          br_n    = 1'b0;
          cnt_n   = '0;
        end
      end
      S_RUN: begin
        a_sr_n = a_sr >> 1;
        b_sr_n = b_sr >> 1;
        // Difference bit enters at the MSB so the LSB-first stream lands in place
        res_n  = (res >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
        br_n   = br_next;
        cnt_n  = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_n = S_DONE;
          d_n     = res_n;
          b_n     = br_next;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign busy_n = (state_n == S_RUN);
  assign done_n = (state_n == S_DONE);

  assign D = d_q;
  assign B = b_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1.

module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done;
  logic [7:0] d_out;
  logic       b_out;

  logic       start1;
  logic [0:0] a1, b1;
  logic       busy1, done1;
  logic [0:0] d1_out;
  logic       b1_out;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .D     (d_out),
    .B     (b_out)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .D     (d1_out),
    .B     (b1_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full operation from an idle unit: accept, WIDTH busy cycles, done pulse, hold
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] exp_d, input logic exp_b,
                        input logic [7:0] prev_d, input logic prev_b);
    start = 1'b1; a = av; b = bv;
    step();
    start = 1'b0; a = ~av; b = ~bv;
    for (int k = 1; k <= 7; k++) begin
      check({tag, " busy"}, 8'(busy), 8'd1);
      check({tag, " done_early"}, 8'(done), 8'd0);
      check({tag, " D_hold"}, d_out, prev_d);
      check({tag, " B_hold"}, 8'(b_out), 8'(prev_b));
      step();
    end
    check({tag, " busy_last"}, 8'(busy), 8'd1);
    step();
    check({tag, " done"}, 8'(done), 8'd1);
    check({tag, " busy_off"}, 8'(busy), 8'd0);
    check({tag, " D"}, d_out, exp_d);
    check({tag, " B"}, 8'(b_out), 8'(exp_b));
    step();
    check({tag, " done_pulse"}, 8'(done), 8'd0);
    check({tag, " D_after"}, d_out, exp_d);
  endtask

  logic [7:0] ops_a [3];
  logic [7:0] ops_b [3];
  logic [7:0] ops_d [3];
  logic       ops_br[3];
  logic [7:0] prev_d;
  logic       prev_b;

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    step(); step();
    check("rst busy", 8'(busy), 8'd0);
    check("rst done", 8'(done), 8'd0);
    check("rst D", d_out, 8'h00);
    check("rst B", 8'(b_out), 8'd0);
    check("rst w1 D", 8'(d1_out), 8'd0);
    check("rst w1 busy", 8'(busy1), 8'd0);
    rst_n = 1'b1;
    step();

    // Basic and boundary operands
    run_op("t1", 8'h5A, 8'h3C, 8'h1E, 1'b0, 8'h00, 1'b0);
    run_op("t2a", 8'h00, 8'h01, 8'hFF, 1'b1, 8'h1E, 1'b0);
    run_op("t2b", 8'hA5, 8'hA5, 8'h00, 1'b0, 8'hFF, 1'b1);

    // start re-pulsed during RUN must be ignored
    start = 1'b1; a = 8'h10; b = 8'h20;
    step();
    start = 1'b0;
    step(); step(); step();
    start = 1'b1; a = 8'hFF; b = 8'h00;
    step();
    start = 1'b0;
    check("t3 busy_mid", 8'(busy), 8'd1);
    step(); step(); step();
    check("t3 busy_last", 8'(busy), 8'd1);
    check("t3 D_hold", d_out, 8'h00);
    step();
    check("t3 done", 8'(done), 8'd1);
    check("t3 D", d_out, 8'hF0);
    check("t3 B", 8'(b_out), 8'd1);
    for (int k = 0; k < 10; k++) begin
      step();
      check("t3 no_second_done", 8'(done), 8'd0);
      check("t3 idle", 8'(busy), 8'd0);
    end

    // Asynchronous reset in the middle of RUN
    start = 1'b1; a = 8'h5A; b = 8'h3C;
    step();
    start = 1'b0;
    step(); step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    check("t4 busy", 8'(busy), 8'd0);
    check("t4 D", d_out, 8'h00);
    check("t4 B", 8'(b_out), 8'd0);
    check("t4 done", 8'(done), 8'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("t4 no_done", 8'(done), 8'd0);
    end
    run_op("t4b", 8'h80, 8'h01, 8'h7F, 1'b0, 8'h00, 1'b0);

    // start held high through DONE: back-to-back ops every 9 cycles
    ops_a[0] = 8'h33; ops_b[0] = 8'h11; ops_d[0] = 8'h22; ops_br[0] = 1'b0;
    ops_a[1] = 8'h11; ops_b[1] = 8'h33; ops_d[1] = 8'hDE; ops_br[1] = 1'b1;
    ops_a[2] = 8'hFF; ops_b[2] = 8'hFF; ops_d[2] = 8'h00; ops_br[2] = 1'b0;
    prev_d = 8'h7F; prev_b = 1'b0;
    start = 1'b1; a = ops_a[0]; b = ops_b[0];
    step();
    for (int i = 0; i < 3; i++) begin
      for (int k = 1; k <= 7; k++) begin
        check("t5 busy", 8'(busy), 8'd1);
        check("t5 done_early", 8'(done), 8'd0);
        check("t5 D_stable", d_out, prev_d);
        check("t5 B_stable", 8'(b_out), 8'(prev_b));
        step();
      end
      if (i < 2) begin
        a = ops_a[i+1]; b = ops_b[i+1];
      end
      step();
      check("t5 done", 8'(done), 8'd1);
      check("t5 D", d_out, ops_d[i]);
      check("t5 B", 8'(b_out), 8'(ops_br[i]));
      prev_d = ops_d[i]; prev_b = ops_br[i];
      if (i == 2) start = 1'b0;
      step();
      check("t5 done_pulse", 8'(done), 8'd0);
      check("t5 busy_next", 8'(busy), (i < 2) ? 8'd1 : 8'd0);
      check("t5 D_kept", d_out, prev_d);
    end

    // WIDTH=1 truth table: (a,b) 00/01/10/11 -> (D,B) 00/11/10/00
    for (int v = 0; v < 4; v++) begin
      logic [1:0] ab;
      logic [1:0] exp_db;
      ab = 2'(v);
      case (ab)
        2'b00:   exp_db = 2'b00;
        2'b01:   exp_db = 2'b11;
        2'b10:   exp_db = 2'b10;
        default: exp_db = 2'b00;
      endcase
      start1 = 1'b1; a1 = ab[1]; b1 = ab[0];
      step();
      start1 = 1'b0;
      check("w1 busy", 8'(busy1), 8'd1);
      check("w1 done_early", 8'(done1), 8'd0);
      step();
      check("w1 done", 8'(done1), 8'd1);
      check("w1 busy_off", 8'(busy1), 8'd0);
      check("w1 D", 8'(d1_out), 8'(exp_db[1]));
      check("w1 B", 8'(b1_out), 8'(exp_db[0]));
      step();
      check("w1 done_pulse", 8'(done1), 8'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
